// File: rtl/hour_cnt_bcd_if.sv
`default_nettype none
// ============================================================================
// Module      : hour_cnt_bcd_if
// Description : Strobe, time-set and display bundle of the BCD hour stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface hour_cnt_bcd_if;
    logic       en_i;
    logic       mode12_i;
    logic       load_i;
    logic [3:0] ld_hour1_i;
    logic [3:0] ld_hour0_i;
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic       pm;
    logic       day_en;
    logic       load_err_o;

    modport master (
        output en_i, mode12_i, load_i, ld_hour1_i, ld_hour0_i,
        input  hour1, hour0, pm, day_en, load_err_o
    );

    modport slave (
        input  en_i, mode12_i, load_i, ld_hour1_i, ld_hour0_i,
        output hour1, hour0, pm, day_en, load_err_o
    );
endinterface
`default_nettype wire

// File: rtl/hour_cnt_bcd.sv
`default_nettype none
// ============================================================================
// Module      : hour_cnt_bcd
// Description : 24h BCD hour counter with 12h/24h display and day carry.
//               Time-set load path enabled by defining HOUR_CNT_LOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hour_cnt_bcd #(
    parameter int RST_HOUR  = 0,
    parameter bit DAY_PULSE = 1'b1
) (
    input  wire logic     clk_i,
    input  wire logic     rst_n,
    hour_cnt_bcd_if.slave bus
);

    localparam logic [3:0] c_RST1 = 4'(RST_HOUR / 10);
    localparam logic [3:0] c_RST0 = 4'(RST_HOUR % 10);

    if (RST_HOUR < 0 || RST_HOUR > 23) begin : g_bad_rst_hour
        $error("hour_cnt_bcd: RST_HOUR must be within 0..23");
    end

    logic [3:0] r_cnt1, r_cnt0;
    logic       r_day_en;
    logic       r_ld_err;

    logic [3:0] w_cnt1_nxt, w_cnt0_nxt;
    logic       w_wrap;
    logic       w_update;
    logic       w_ld_err;
    logic       w_day_nxt;
    logic       w_ld_ok;
    logic       w_ld_bad;

`ifdef HOUR_CNT_LOAD_EN
    logic w_ld_valid;
    assign w_ld_valid = (bus.ld_hour1_i <  4'd2 && bus.ld_hour0_i <= 4'd9) ||
                        (bus.ld_hour1_i == 4'd2 && bus.ld_hour0_i <= 4'd3);
    assign w_ld_ok    = bus.load_i &  w_ld_valid;
    assign w_ld_bad   = bus.load_i & ~w_ld_valid;
`else
    logic w_ld_unused;
    assign w_ld_unused = &{1'b0, bus.load_i, bus.ld_hour1_i, bus.ld_hour0_i};
    assign w_ld_ok     = 1'b0;
    assign w_ld_bad    = 1'b0;
`endif

    // A rejected load still takes priority over en_i: the count holds.
    always_comb begin
        w_cnt1_nxt = r_cnt1;
        w_cnt0_nxt = r_cnt0;
        w_wrap     = 1'b0;
        w_update   = 1'b0;
        w_ld_err   = 1'b0;
        if (w_ld_ok) begin
            w_cnt1_nxt = bus.ld_hour1_i;
            w_cnt0_nxt = bus.ld_hour0_i;
            w_update   = 1'b1;
        end else if (w_ld_bad) begin
            w_ld_err   = 1'b1;
        end else if (bus.en_i) begin
            w_update = 1'b1;
            if (r_cnt1 == 4'd2 && r_cnt0 == 4'd3) begin
                w_cnt1_nxt = 4'd0;
                w_cnt0_nxt = 4'd0;
                w_wrap     = 1'b1;
            end else if (r_cnt0 == 4'd9) begin
                w_cnt1_nxt = r_cnt1 + 4'd1;
                w_cnt0_nxt = 4'd0;
            end else begin
                w_cnt0_nxt = r_cnt0 + 4'd1;
            end
        end
    end

    if (DAY_PULSE) begin : g_day_pulse
        assign w_day_nxt = w_wrap;
    end else begin : g_day_level
        // Level holds across idle cycles and rejected loads; any real update clears it.
        assign w_day_nxt = w_wrap | (r_day_en & ~w_update);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt1   <= c_RST1;
            r_cnt0   <= c_RST0;
            r_day_en <= 1'b0;
            r_ld_err <= 1'b0;
        end else begin
            r_cnt1   <= w_cnt1_nxt;
            r_cnt0   <= w_cnt0_nxt;
            r_day_en <= w_day_nxt;
            r_ld_err <= w_ld_err;
        end
    end

    logic [4:0] w_bin;
    logic [4:0] w_disp;
    logic [3:0] w_d1, w_d0;

    assign w_bin = 5'(r_cnt1) * 5'd10 + 5'(r_cnt0);

    always_comb begin
        w_disp = w_bin;
        if (bus.mode12_i) begin
            if (w_bin == 5'd0) begin
                w_disp = 5'd12;
            end else if (w_bin > 5'd12) begin
                w_disp = w_bin - 5'd12;
            end
        end
    end

    always_comb begin
        w_d1 = 4'd0;
        w_d0 = w_disp[3:0];
        if (w_disp >= 5'd20) begin
            w_d1 = 4'd2;
            w_d0 = 4'(w_disp - 5'd20);
        end else if (w_disp >= 5'd10) begin
            w_d1 = 4'd1;
            w_d0 = 4'(w_disp - 5'd10);
        end
    end

    assign bus.hour1      = w_d1;
    assign bus.hour0      = w_d0;
    assign bus.pm         = (w_bin >= 5'd12);
    assign bus.day_en     = r_day_en;
    assign bus.load_err_o = r_ld_err;

endmodule
`default_nettype wire

// File: tb/tb_hour_cnt_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_hour_cnt_bcd
// Description : Self-checking bench for hour_cnt_bcd against an hour-number model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hour_cnt_bcd;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hour_cnt_bcd_if bus ();

    hour_cnt_bcd dut (
        .clk_i (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: hour as a plain integer, plus expected carry and error flags.
    int m_hour = 0;
    bit m_day  = 1'b0;
    bit m_err  = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp_of(input int h, input bit m12);
        if (!m12)        return h;
        if (h % 12 == 0) return 12;
        return h % 12;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            int d;
            d = disp_of(m_hour, bus.mode12_i);
            chk("hour1",    bus.hour1,      8'(d / 10));
            chk("hour0",    bus.hour0,      8'(d % 10));
            chk("pm",       8'(bus.pm),     8'(m_hour >= 12));
            chk("day_en",   8'(bus.day_en), 8'(m_day));
            chk("load_err", 8'(bus.load_err_o), 8'(m_err));
        end
    end

    task automatic step(input bit en, input bit ld = 1'b0,
                        input logic [3:0] h1 = 4'd0, input logic [3:0] h0 = 4'd0);
        int nh;
        bit nd, ne, ld_eff;
        bus.en_i       = en;
        bus.load_i     = ld;
        bus.ld_hour1_i = h1;
        bus.ld_hour0_i = h0;
`ifdef HOUR_CNT_LOAD_EN
        ld_eff = ld;
`else
        ld_eff = 1'b0;
`endif
        nh = m_hour; nd = 1'b0; ne = 1'b0;
        if (ld_eff) begin
            if (h1 <= 9 && h0 <= 9 && int'(h1) * 10 + int'(h0) <= 23) nh = int'(h1) * 10 + int'(h0);
            else ne = 1'b1;
        end else if (en) begin
            nd = (m_hour == 23);
            nh = (m_hour + 1) % 24;
        end
        @(posedge clk);
        #1;
        m_hour = nh; m_day = nd; m_err = ne;
        bus.en_i   = 1'b0;
        bus.load_i = 1'b0;
    endtask

    initial begin
        int guard;
        bus.en_i = 1'b0; bus.mode12_i = 1'b0; bus.load_i = 1'b0;
        bus.ld_hour1_i = 4'd0; bus.ld_hour0_i = 4'd0;
        #1;
        chk("rst_hour1", bus.hour1, 8'd0);
        chk("rst_hour0", bus.hour0, 8'd0);
        chk("rst_day",   8'(bus.day_en), 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(posedge clk); #1;

        repeat (10) step(1'b0);
        chk("idle_hour0", bus.hour0, 8'd0);
        chk("idle_pm",    8'(bus.pm), 8'd0);

        // 24h sweep, back-to-back ticks
        for (int i = 0; i < 24; i++) begin
            step(1'b1);
            if (i == 8)  begin chk("h09_t", bus.hour1, 8'd0); chk("h09_u", bus.hour0, 8'd9); end
            if (i == 9)  begin chk("h10_t", bus.hour1, 8'd1); chk("h10_u", bus.hour0, 8'd0); end
            if (i == 22) begin chk("h23_t", bus.hour1, 8'd2); chk("h23_u", bus.hour0, 8'd3); end
            if (i == 23) begin
                chk("wrap_t",   bus.hour1, 8'd0);
                chk("wrap_u",   bus.hour0, 8'd0);
                chk("wrap_day", 8'(bus.day_en), 8'd1);
            end
        end
        step(1'b0);
        chk("day_drop", 8'(bus.day_en), 8'd0);

        // 12h display sweep
        bus.mode12_i = 1'b1;
        #1;
        chk("m12_00_t", bus.hour1, 8'd1);
        chk("m12_00_u", bus.hour0, 8'd2);
        for (int i = 0; i < 24; i++) begin
            step(1'b1);
            if (i == 12) begin
                chk("m12_13_t", bus.hour1, 8'd0);
                chk("m12_13_u", bus.hour0, 8'd1);
                chk("m12_13_pm", 8'(bus.pm), 8'd1);
            end
            if (i == 11) begin
                chk("m12_12_t", bus.hour1, 8'd1);
                chk("m12_12_u", bus.hour0, 8'd2);
            end
        end
        repeat (5) step(1'b1);
        bus.mode12_i = 1'b0;
        #1;
        chk("mode_sw_u", bus.hour0, 8'd5);
        step(1'b0);
        bus.mode12_i = 1'b1;
        step(1'b1);
        bus.mode12_i = 1'b0;

`ifdef HOUR_CNT_LOAD_EN
        step(1'b0, 1'b1, 4'd2, 4'd3);
        chk("ld23_t", bus.hour1, 8'd2);
        chk("ld23_u", bus.hour0, 8'd3);
        step(1'b1);
        chk("ld_wrap_u",   bus.hour0, 8'd0);
        chk("ld_wrap_day", 8'(bus.day_en), 8'd1);
        step(1'b1, 1'b1, 4'd2, 4'd3);
        chk("ld_en_u",   bus.hour0, 8'd3);
        chk("ld_en_day", 8'(bus.day_en), 8'd0);
        step(1'b0, 1'b1, 4'd2, 4'd4);
        chk("ld24_err", 8'(bus.load_err_o), 8'd1);
        chk("ld24_u",   bus.hour0, 8'd3);
        step(1'b1, 1'b1, 4'd1, 4'hA);
        chk("ld1A_err", 8'(bus.load_err_o), 8'd1);
        step(1'b0, 1'b1, 4'd0, 4'd0);
        chk("ld00_day", 8'(bus.day_en), 8'd0);
        chk("ld00_err", 8'(bus.load_err_o), 8'd0);
`else
        step(1'b0, 1'b1, 4'd2, 4'd3);
        step(1'b0, 1'b1, 4'd2, 4'd4);
        chk("noload_err", 8'(bus.load_err_o), 8'd0);
        chk("noload_u",   bus.hour0, 8'(m_hour % 10));
`endif

        // Async reset mid-count
        guard = 0;
        while (m_hour != 17 && guard < 30) begin
            step(1'b1);
            guard++;
        end
        chk("reach17", bus.hour0, 8'd7);
        bus.en_i = 1'b1;
        #2;
        rst_n  = 1'b0;
        m_hour = 0; m_day = 1'b0; m_err = 1'b0;
        #1;
        chk("arst_t",   bus.hour1, 8'd0);
        chk("arst_u",   bus.hour0, 8'd0);
        chk("arst_day", 8'(bus.day_en), 8'd0);
        @(posedge clk); #1;
        chk("arst_hold", bus.hour0, 8'd0);
        bus.en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b0);
        step(1'b1);
        chk("post_rst", bus.hour0, 8'd1);
        step(1'b0);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
